// File: rtl/instr_decode_stage.sv
// Decode stage: splits fetched instructions into fields and queues them in a 2-entry FIFO.
// Unconditional jumps redirect fetch and squash the following delay beat.
module instr_decode_stage #(
   parameter int          ADDR_WIDTH = 8,
   parameter int          DATA_WIDTH = 32,
   parameter logic [5:0]  JMP_OPCODE = 6'h3F
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic [ADDR_WIDTH-1:0] pc_in,
   input  logic [DATA_WIDTH-1:0] instr_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic [5:0]            opcode,
   output logic [4:0]            rd,
   output logic [4:0]            rs1,
   output logic [4:0]            rs2,
   output logic [15:0]           imm,
   output logic                  branch_en,
   output logic [ADDR_WIDTH-1:0] branch_addr,
   output logic [15:0]           issue_count
);

   typedef enum logic {RUN, SQUASH} state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [5:0]            opcode;
      logic [4:0]            rd;
      logic [4:0]            rs1;
      logic [4:0]            rs2;
      logic [15:0]           imm;
   } entry_t;

   state_t     state_q, state_d;
   entry_t     head_q, tail_q, new_entry;
   logic [1:0] count_q;
   logic       in_hs, out_hs, is_jump, push, take_branch;

   assign in_ready  = (count_q < 2'd2) && !flush;
   assign out_valid = (count_q != 2'd0);
   assign in_hs     = in_valid && in_ready;
   assign out_hs    = out_valid && out_ready;
   assign is_jump   = (instr_in[31:26] == JMP_OPCODE);

   assign new_entry.pc     = pc_in;
   assign new_entry.opcode = instr_in[31:26];
   assign new_entry.rd     = instr_in[25:21];
   assign new_entry.rs1    = instr_in[20:16];
   assign new_entry.rs2    = instr_in[15:11];
   assign new_entry.imm    = instr_in[15:0];

   assign pc_out = head_q.pc;
   assign opcode = head_q.opcode;
   assign rd     = head_q.rd;
   assign rs1    = head_q.rs1;
   assign rs2    = head_q.rs2;
   assign imm    = head_q.imm;

   always_comb begin
      state_d     = state_q;
      push        = 1'b0;
      take_branch = 1'b0;
      if (flush) begin
         state_d = RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (in_hs) begin
                  if (is_jump) begin
                     take_branch = 1'b1;
                     state_d     = SQUASH;
                  end else begin
                     push = 1'b1;
                  end
               end
            end
            SQUASH: begin
               if (in_hs) state_d = RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q     <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         branch_en   <= 1'b0;
         branch_addr <= '0;
         issue_count <= '0;
      end else if (flush) begin
         count_q   <= '0;
         branch_en <= 1'b0;
      end else begin
         branch_en <= take_branch;
         if (take_branch) branch_addr <= instr_in[ADDR_WIDTH-1:0];
         if (out_hs) issue_count <= issue_count + 16'd1;
         case ({push, out_hs})
            2'b10: begin
               if (count_q == 2'd0) begin
                  head_q  <= new_entry;
                  count_q <= 2'd1;
               end else begin
                  tail_q  <= new_entry;
                  count_q <= 2'd2;
               end
            end
            2'b01: begin
               head_q  <= tail_q;
               count_q <= count_q - 2'd1;
            end
            // push needs count<2 and pop needs count>0, so count is 1 here
            2'b11: head_q <= new_entry;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- ADDR_WIDTH, 8, PC and branch-target width.
- DATA_WIDTH, 32, instruction width.
- JMP_OPCODE, 6'h3F, opcode of the unconditional jump.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous, active-high.
- flush, in, 1, synchronous pipeline clear.
- pc_in, in, ADDR_WIDTH, PC from the fetch stage.
- instr_in, in, DATA_WIDTH, instruction from the fetch stage.
- in_valid, in, 1, fetch beat valid.
- in_ready, out, 1, decode can accept a beat.
- out_valid, out, 1, decoded entry available.
- out_ready, in, 1, downstream accepts the entry.
- pc_out, out, ADDR_WIDTH, PC of the head entry.
- opcode, out, 6, instr[31:26] of the head entry.
- rd, out, 5, instr[25:21] of the head entry.
- rs1, out, 5, instr[20:16] of the head entry.
- rs2, out, 5, instr[15:11] of the head entry.
- imm, out, 16, instr[15:0] of the head entry.
- branch_en, out, 1, one-cycle redirect pulse to fetch.
- branch_addr, out, ADDR_WIDTH, redirect target.
- issue_count, out, 16, count of output handshakes.

Function
REQ-003 An input handshake SHALL occur when in_valid=1 and in_ready=1; an output handshake SHALL occur when out_valid=1 and out_ready=1.
REQ-004 The block SHALL hold a 2-entry FIFO of decoded entries, each entry being {pc, opcode, rd, rs1, rs2, imm}.
REQ-005 in_ready SHALL be 1 iff the FIFO count is less than 2 and flush=0; it SHALL NOT depend combinationally on out_ready.
REQ-006 out_valid SHALL be 1 iff the FIFO count is nonzero; the output fields SHALL show the head entry and be stable while out_valid=1 and out_ready=0.
REQ-007 When the FIFO is empty, an entry accepted at edge N SHALL be visible at the output after edge N (one-cycle latency).
REQ-008 With count=1, a simultaneous input and output handshake SHALL leave count at 1, with the new entry becoming the head.
REQ-009 The FSM SHALL have two states, RUN and SQUASH.
REQ-010 In RUN, an accepted beat whose opcode is not JMP_OPCODE SHALL be pushed into the FIFO.
REQ-011 In RUN, an accepted beat whose opcode equals JMP_OPCODE SHALL NOT be pushed; on the next cycle the block SHALL drive branch_en=1 and branch_addr=instr_in[ADDR_WIDTH-1:0], and the state SHALL become SQUASH.
REQ-012 In SQUASH, the next accepted beat SHALL be discarded whatever its opcode, and the state SHALL return to RUN.
REQ-013 While in SQUASH with no accepted beat, the state SHALL remain SQUASH.
REQ-014 branch_en SHALL be high for exactly one cycle per accepted jump; branch_addr SHALL hold its last value otherwise.
REQ-015 issue_count SHALL increment by 1 on every output handshake and SHALL wrap from 16'hFFFF to 0.
REQ-016 When flush=1 at a rising edge, the block SHALL empty the FIFO, set the state to RUN, drive branch_en=0 on the next cycle, ignore input that cycle, and leave issue_count unchanged.
REQ-017 flush SHALL take priority over all other events in the same cycle, including a pending branch pulse.
REQ-018 Opcode 0 (NOP) SHALL be forwarded like any other non-jump instruction.

Reset
REQ-019 While reset=1, the block SHALL asynchronously force: FIFO count=0, state=RUN, out_valid=0, branch_en=0, branch_addr=0, issue_count=0, and all output fields=0.
REQ-020 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-021 Reset asserted mid-operation SHALL discard all FIFO contents and cancel any pending branch pulse.

Verification
REQ-022 Streaming: out_ready=1; push instr 32'h0443_0005 at pc=3 -> next cycle out_valid=1, pc_out=3, opcode=1, rd=2, rs1=3, rs2=0, imm=5; issue_count=1 after the handshake.
REQ-023 Backpressure: out_ready=0; push 3 beats -> count=2, in_ready=0, third beat held; raise out_ready -> entries emerge in order with no loss or duplication.
REQ-024 Jump: push opcode 6'h3F with instr[7:0]=8'h40, then one ordinary beat -> branch_en=1 for one cycle, branch_addr=8'h40; neither beat appears at the output; the following beat is forwarded.
REQ-025 Flush: with 2 entries queued and the state in SQUASH, pulse flush -> out_valid=0, state=RUN next cycle, issue_count unchanged.
REQ-026 Wrap and reset: preload issue_count=16'hFFFF by 65535 output handshakes, perform one more -> issue_count=0; assert reset mid-stream -> all outputs are 0 immediately, without waiting for a clock edge.
